// File: rtl/switch_latch_pkg.sv
// switch_latch_pkg
//   Shared constants and helpers for the switch latch bank.
//   POL_*            : handling of a set and a reset edge arriving in the same cycle
//   dwell_cnt_width  : bit width of the per-channel dwell down-counter
package switch_latch_pkg;

  localparam int POL_KEEP = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;

  // The counter must hold HOLD_CYCLES. When HOLD_CYCLES is 0 the width
  // stays at 1 so the counter register is never zero-width.
  function automatic int dwell_cnt_width(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings one asynchronous line into the i_clk domain through a flop chain.
//   A history flop follows the chain and gives a one-cycle pulse on each
//   rising edge at the chain output.
//   i_clk   : clock
//   i_reset : asynchronous active-high reset, clears the chain and history
//   i_d     : asynchronous input line
//   o_rise  : one-cycle rising-edge pulse, synchronous to i_clk
module sync_edge_det
  import switch_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/switch_latch_bank.sv
// switch_latch_bank
//   Bank of NUM_CH independent set/reset latches for the photonic switch
//   controls. Each channel has its own synchronised edge detectors, a dwell
//   timer that blocks further edges after a change, and status strobes.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   s_in    : asynchronous set lines, rising edge significant
//   r_in    : asynchronous reset lines, rising edge significant
//   clr     : synchronous per-channel force-to-0, overrides everything
//   out     : latched channel state
//   out_chg : one-cycle strobe in the cycle after out changed
//   busy    : channel is inside its dwell window
//   dropped : one-cycle strobe, an edge on this channel was discarded
module switch_latch_bank
  import switch_latch_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 0,
  parameter int SIMUL_POLICY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] s_in,
  input  logic [NUM_CH-1:0] r_in,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] out_chg,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] dropped
);

  localparam int              CW      = dwell_cnt_width(HOLD_CYCLES);
  localparam int              AW      = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]   HOLD_LD = CW'(HOLD_CYCLES);
  localparam logic [AW-1:0]   ARM_LD  = AW'(SYNC_STAGES + 1);

  // Shared arming timer. A line held high across reset release looks like a
  // rising edge once the chain fills; masking detection until the chain and
  // history flop have settled hides that false event.
  logic [AW-1:0] r_arm_cnt;
  logic          w_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm_cnt <= ARM_LD;
    end else if (r_arm_cnt != '0) begin
      r_arm_cnt <= r_arm_cnt - AW'(1);
    end
  end

  assign w_armed = (r_arm_cnt == '0);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic          w_se_raw;
    logic          w_re_raw;
    logic          w_se;
    logic          w_re;
    logic          w_both;
    logic          w_set_win;
    logic          w_rst_win;
    logic          w_busy;
    logic          r_out;
    logic          r_chg;
    logic          r_drop;
    logic [CW-1:0] r_cnt;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_set_det (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (s_in[g]),
      .o_rise  (w_se_raw)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_rst_det (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (r_in[g]),
      .o_rise  (w_re_raw)
    );

    assign w_se   = w_se_raw & w_armed;
    assign w_re   = w_re_raw & w_armed;
    assign w_busy = (r_cnt != '0);

    // Under the keep policy neither edge wins; the both-edges case is caught
    // ahead of the win terms in the update below.
    always_comb begin
      w_both    = w_se & w_re;
      w_set_win = w_se & (~w_re | (SIMUL_POLICY == POL_SET));
      w_rst_win = w_re & (~w_se | (SIMUL_POLICY == POL_RST));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_out  <= 1'b0;
        r_chg  <= 1'b0;
        r_drop <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_chg  <= 1'b0;
        r_drop <= 1'b0;
        if (clr[g]) begin
          // Edges coinciding with clr are swallowed without a drop strobe.
          r_out <= 1'b0;
          r_cnt <= '0;
          r_chg <= r_out;
        end else if (w_busy) begin
          r_cnt  <= r_cnt - CW'(1);
          r_drop <= w_se | w_re;
        end else if (w_both && (SIMUL_POLICY == POL_KEEP)) begin
          r_drop <= 1'b1;
        end else if (w_set_win && !r_out) begin
          r_out <= 1'b1;
          r_chg <= 1'b1;
          r_cnt <= HOLD_LD;
        end else if (w_rst_win && r_out) begin
          r_out <= 1'b0;
          r_chg <= 1'b1;
          r_cnt <= HOLD_LD;
        end
      end
    end

    assign out[g]     = r_out;
    assign out_chg[g] = r_chg;
    assign busy[g]    = w_busy;
    assign dropped[g] = r_drop;
  end

endmodule

// File: tb/tb_switch_latch_bank.sv
// tb_switch_latch_bank
//   Three bank instances with different synchroniser depth, dwell and
//   simultaneous-edge policy share one set of stimulus lines. A behavioural
//   model schedules each sampled rising edge to land SYNC_STAGES edges later
//   and applies the latch rules per channel with plain integers.
module tb_switch_latch_bank;

  localparam int NCH = 4;
  localparam int ND  = 3;
  localparam int PS [ND] = '{2, 2, 3};
  localparam int PH [ND] = '{0, 5, 2};
  localparam int PP [ND] = '{0, 1, 2};

  typedef struct packed {
    logic           rel;
    logic [NCH-1:0] s;
    logic [NCH-1:0] r;
    logic [NCH-1:0] c;
  } stim_t;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] s_in  = '0;
  logic [NCH-1:0] r_in  = '0;
  logic [NCH-1:0] clr   = '0;

  logic [NCH-1:0] o_out  [ND];
  logic [NCH-1:0] o_chg  [ND];
  logic [NCH-1:0] o_busy [ND];
  logic [NCH-1:0] o_drop [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    switch_latch_bank #(
      .NUM_CH       (NCH),
      .SYNC_STAGES  (PS[g]),
      .HOLD_CYCLES  (PH[g]),
      .SIMUL_POLICY (PP[g])
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .s_in    (s_in),
      .r_in    (r_in),
      .clr     (clr),
      .out     (o_out[g]),
      .out_chg (o_chg[g]),
      .busy    (o_busy[g]),
      .dropped (o_drop[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int             k;
  logic [NCH-1:0] prev_s, prev_r;
  logic [NCH-1:0] ev_s [ND][16];
  logic [NCH-1:0] ev_r [ND][16];
  logic [NCH-1:0] m_out  [ND];
  logic [NCH-1:0] m_chg  [ND];
  logic [NCH-1:0] m_drop [ND];
  int             m_dw   [ND][NCH];

  task automatic model_reset();
    k      = 0;
    prev_s = '0;
    prev_r = '0;
    for (int d = 0; d < ND; d++) begin
      m_out[d]  = '0;
      m_chg[d]  = '0;
      m_drop[d] = '0;
      for (int i = 0; i < NCH; i++) m_dw[d][i] = 0;
      for (int j = 0; j < 16; j++) begin
        ev_s[d][j] = '0;
        ev_r[d][j] = '0;
      end
    end
  endtask

  task automatic model_edge(input logic [NCH-1:0] s, input logic [NCH-1:0] r,
                            input logic [NCH-1:0] c);
    logic [NCH-1:0] se, re;
    bit want_set, want_rst;
    k++;
    for (int d = 0; d < ND; d++) begin
      se = ev_s[d][k % 16];
      re = ev_r[d][k % 16];
      ev_s[d][k % 16] = '0;
      ev_r[d][k % 16] = '0;
      // An edge sampled at the first edge after release is the reset artefact.
      if (k >= 2) begin
        ev_s[d][(k + PS[d]) % 16] |= s & ~prev_s;
        ev_r[d][(k + PS[d]) % 16] |= r & ~prev_r;
      end
      for (int i = 0; i < NCH; i++) begin
        m_chg[d][i]  = 1'b0;
        m_drop[d][i] = 1'b0;
        if (c[i]) begin
          m_chg[d][i] = m_out[d][i];
          m_out[d][i] = 1'b0;
          m_dw[d][i]  = 0;
        end else if (m_dw[d][i] > 0) begin
          m_drop[d][i] = se[i] | re[i];
          m_dw[d][i]   = m_dw[d][i] - 1;
        end else begin
          want_set = se[i];
          want_rst = re[i];
          if (want_set && want_rst) begin
            if (PP[d] == 0) begin
              m_drop[d][i] = 1'b1;
              want_set = 0;
              want_rst = 0;
            end else if (PP[d] == 1) begin
              want_rst = 0;
            end else begin
              want_set = 0;
            end
          end
          if (want_set && !m_out[d][i]) begin
            m_out[d][i] = 1'b1;
            m_chg[d][i] = 1'b1;
            m_dw[d][i]  = PH[d];
          end else if (want_rst && m_out[d][i]) begin
            m_out[d][i] = 1'b0;
            m_chg[d][i] = 1'b1;
            m_dw[d][i]  = PH[d];
          end
        end
      end
    end
    prev_s = s;
    prev_r = r;
  endtask

  function automatic logic [4*NCH-1:0] exp_vec(input int d);
    logic [NCH-1:0] b;
    for (int i = 0; i < NCH; i++) b[i] = (m_dw[d][i] > 0);
    return {m_out[d], m_chg[d], b, m_drop[d]};
  endfunction

  function automatic logic [4*NCH-1:0] obs_vec(input int d);
    return {o_out[d], o_chg[d], o_busy[d], o_drop[d]};
  endfunction

  function automatic stim_t mk(input logic [NCH-1:0] s, input logic [NCH-1:0] r,
                               input logic [NCH-1:0] c);
    stim_t t;
    t.rel = 1'b0;
    t.s   = s;
    t.r   = r;
    t.c   = c;
    return t;
  endfunction

  // One clock: drive at the falling edge, let the model take the rising edge,
  // leave the caller 1 time unit after the rising edge to sample.
  task automatic step(input stim_t t);
    @(negedge clk);
    s_in = t.s;
    r_in = t.r;
    clr  = t.c;
    if (t.rel) begin
      reset = 1'b0;
      model_reset();
    end
    @(posedge clk);
    model_edge(t.s, t.r, t.c);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t          q[$];
    stim_t          t;
    logic [NCH-1:0] seen;
    seen  = '0;
    reset = 1'b1;
    s_in  = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (obs_vec(d) !== '0) begin
        bad++;
        $display("FAIL reset_values dut%0d got=%h want=0", d, obs_vec(d));
      end
    end
    t     = mk(4'b0001, '0, '0);
    t.rel = 1'b1;
    q.push_back(t);
    for (int i = 0; i < 9; i++) q.push_back(mk(4'b0001, '0, '0));
    for (int i = 0; i < 4; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        seen |= o_chg[d] | o_drop[d];
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL reset_hold dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
      if (i == 9) begin
        for (int d = 0; d < ND; d++) begin
          total++;
          if (o_out[d] !== '0) begin
            bad++;
            $display("FAIL reset_held_line dut%0d out=%b want=0000", d, o_out[d]);
          end
        end
      end
    end
    total++;
    if (seen !== '0) begin
      bad++;
      $display("FAIL reset_no_strobe seen=%b want=0000", seen);
    end
  endtask

  task automatic test_set_reset();
    stim_t q[$];
    int    chg_cnt;
    chg_cnt = 0;
    q.push_back(mk('0, '0, 4'hF));
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b0010, '0, '0));                       // idx 9: captured at k
    for (int i = 0; i < 4; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b0010, '0, '0));                       // idx 14: repeat set
    for (int i = 0; i < 5; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, 4'b0010, '0));                       // idx 20: reset pulse
    for (int i = 0; i < 5; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL set_reset dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
      if (i >= 14 && i <= 19) chg_cnt += int'(o_chg[0][1]);
      if (i == 10) begin
        total++;
        if (o_out[0][1] !== 1'b0) begin
          bad++;
          $display("FAIL set_too_early out=%b want=0", o_out[0][1]);
        end
      end
      if (i == 11) begin
        total++;
        if (o_out[0][1] !== 1'b1 || o_chg[0][1] !== 1'b1) begin
          bad++;
          $display("FAIL set_latency out=%b chg=%b want=1,1", o_out[0][1], o_chg[0][1]);
        end
      end
      if (i == 19) begin
        total++;
        if (chg_cnt != 0 || o_out[0][1] !== 1'b1) begin
          bad++;
          $display("FAIL set_repeat chg_cnt=%0d out=%b want=0,1", chg_cnt, o_out[0][1]);
        end
      end
      if (i == 22) begin
        total++;
        if (o_out[0][1] !== 1'b0) begin
          bad++;
          $display("FAIL reset_pulse out=%b want=0", o_out[0][1]);
        end
      end
    end
  endtask

  task automatic test_dwell();
    stim_t q[$];
    int    bcnt;
    bcnt = 0;
    q.push_back(mk('0, '0, 4'b0001));
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b0001, '0, '0));                       // idx 9
    q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, '0, '0));                            // idx 11: change edge n
    q.push_back(mk('0, 4'b0001, '0));                       // idx 12: n+1
    q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, '0, '0));                            // idx 14: n+3 detect
    q.push_back(mk('0, 4'b0001, '0));                       // idx 15: n+4
    q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, '0, '0));                            // idx 17: n+6 detect
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL dwell dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
      if (i >= 11 && i <= 16) bcnt += int'(o_busy[1][0]);
      if (i == 11) begin
        total++;
        if (o_out[1][0] !== 1'b1 || o_busy[1][0] !== 1'b1) begin
          bad++;
          $display("FAIL dwell_start out=%b busy=%b want=1,1", o_out[1][0], o_busy[1][0]);
        end
      end
      if (i == 14) begin
        total++;
        if (o_drop[1][0] !== 1'b1 || o_out[1][0] !== 1'b1) begin
          bad++;
          $display("FAIL dwell_drop dropped=%b out=%b want=1,1", o_drop[1][0], o_out[1][0]);
        end
      end
      if (i == 16) begin
        total++;
        if (bcnt != 5) begin
          bad++;
          $display("FAIL dwell_busy_len got=%0d want=5", bcnt);
        end
      end
      if (i == 17) begin
        total++;
        if (o_out[1][0] !== 1'b0) begin
          bad++;
          $display("FAIL dwell_after out=%b want=0", o_out[1][0]);
        end
      end
    end
  endtask

  task automatic test_simul();
    stim_t q[$];
    logic  drop0, strobe2;
    drop0   = 1'b0;
    strobe2 = 1'b0;
    q.push_back(mk('0, '0, 4'hF));
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b0100, 4'b0100, '0));                  // idx 9
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL simul dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
      if (i >= 10) begin
        drop0   |= o_drop[0][2];
        strobe2 |= o_drop[2][2] | o_chg[2][2];
      end
    end
    total++;
    if (o_out[0][2] !== 1'b0 || drop0 !== 1'b1) begin
      bad++;
      $display("FAIL simul_keep out=%b dropped_seen=%b want=0,1", o_out[0][2], drop0);
    end
    total++;
    if (o_out[1][2] !== 1'b1) begin
      bad++;
      $display("FAIL simul_set out=%b want=1", o_out[1][2]);
    end
    total++;
    if (o_out[2][2] !== 1'b0 || strobe2 !== 1'b0) begin
      bad++;
      $display("FAIL simul_rst out=%b strobe_seen=%b want=0,0", o_out[2][2], strobe2);
    end
  endtask

  task automatic test_clr();
    stim_t q[$];
    q.push_back(mk('0, '0, 4'b1000));
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b1000, '0, '0));                       // idx 9: k
    q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, '0, '0));                            // idx 11: set at k+2
    q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'b1000, '0, '0));                       // idx 13: detect at k+6
    q.push_back(mk('0, '0, '0));
    q.push_back(mk('0, '0, 4'b1000));                       // idx 15: clr at k+6
    for (int i = 0; i < 6; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL clr dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
      if (i == 14) begin
        total++;
        if (o_out[1][3] !== 1'b1 || o_busy[1][3] !== 1'b1) begin
          bad++;
          $display("FAIL clr_pre out=%b busy=%b want=1,1", o_out[1][3], o_busy[1][3]);
        end
      end
      if (i == 15) begin
        total++;
        if ({o_out[1][3], o_chg[1][3], o_busy[1][3], o_drop[1][3]} !== 4'b0100) begin
          bad++;
          $display("FAIL clr_act out/chg/busy/drop=%b%b%b%b want=0100",
                   o_out[1][3], o_chg[1][3], o_busy[1][3], o_drop[1][3]);
        end
      end
      if (i == 16) begin
        total++;
        if (o_out[1][3] !== 1'b0 || o_chg[1][3] !== 1'b0) begin
          bad++;
          $display("FAIL clr_after out=%b chg=%b want=0,0", o_out[1][3], o_chg[1][3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    stim_t q[$];
    stim_t t;
    q.push_back(mk('0, '0, 4'hF));
    for (int i = 0; i < 8; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'hF, '0, '0));
    for (int i = 0; i < 3; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL pre_reset dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
    end
    total++;
    if (o_busy[1] !== 4'hF) begin
      bad++;
      $display("FAIL mid_dwell_setup busy=%b want=1111", o_busy[1]);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    s_in  = '0;
    r_in  = '0;
    clr   = '0;
    #1;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (obs_vec(d) !== '0) begin
        bad++;
        $display("FAIL async_reset dut%0d got=%h want=0", d, obs_vec(d));
      end
    end
    model_reset();
    repeat (2) @(posedge clk);
    q.delete();
    t     = mk('0, '0, '0);
    t.rel = 1'b1;
    q.push_back(t);
    for (int i = 0; i < 3; i++) q.push_back(mk('0, '0, '0));
    q.push_back(mk(4'hF, '0, '0));
    for (int i = 0; i < 6; i++) q.push_back(mk('0, '0, '0));
    for (int i = 0; i < q.size(); i++) begin
      step(q[i]);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL post_reset dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      total++;
      if (o_out[d] !== 4'hF) begin
        bad++;
        $display("FAIL resume_set dut%0d out=%b want=1111", d, o_out[d]);
      end
    end
  endtask

  task automatic test_random();
    stim_t t;
    for (int i = 0; i < 400; i++) begin
      t = mk(NCH'($urandom & $urandom), NCH'($urandom & $urandom),
             NCH'($urandom & $urandom & $urandom & $urandom & $urandom));
      step(t);
      for (int d = 0; d < ND; d++) begin
        total++;
        if (obs_vec(d) !== exp_vec(d)) begin
          bad++;
          $display("FAIL random dut%0d k=%0d got=%h want=%h", d, k, obs_vec(d), exp_vec(d));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_reset();
    test_dwell();
    test_simul();
    test_clr();
    test_reset_mid_dwell();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/switch_latch_bank.md
# switch_latch_bank

Parametrised bank of NUM_CH independent set/reset latches driving the photonic switch controls. Each channel takes asynchronous set and reset pulse lines, synchronises them to `clk`, and detects rising edges. It keeps one output bit per channel. The bank adds three things a single latch cell lacks: a per-channel minimum dwell time, a policy for simultaneous set/reset, and status strobes. It sits between the detector/trigger inputs and the switch driver outputs.

## Interface
- NUM_CH, 4, number of independent latch channels (1..32)
- SYNC_STAGES, 2, synchroniser depth per input line (2..4)
- HOLD_CYCLES, 0, minimum dwell in `clk` cycles after an output change; 0 disables dwell
- SIMUL_POLICY, 0, simultaneous set+reset edge handling: 0 = keep state, 1 = set wins, 2 = reset wins
- clk  input  1  system clock; all state except the synchroniser first stage is in this domain
- reset  input  1  reset, asynchronous, active-high
- s_in  input  NUM_CH  asynchronous set pulse lines, rising-edge significant
- r_in  input  NUM_CH  asynchronous reset pulse lines, rising-edge significant
- clr  input  NUM_CH  synchronous per-channel force-to-0
- out  output  NUM_CH  latched channel state
- out_chg  output  NUM_CH  one-cycle strobe in the cycle after `out` changed
- busy  output  NUM_CH  channel is in its dwell window
- dropped  output  NUM_CH  one-cycle strobe: an edge on this channel was discarded

## Operation
- Reset values: out=0, out_chg=0, busy=0, dropped=0. All synchroniser, history and dwell registers are 0.
- Arming:
  - After reset deasserts, edge detection is masked for SYNC_STAGES+1 cycles.
  - A line held high through reset release produces no event.
- Per channel, an edge event `se`/`re` is a rising edge at the synchroniser output.
- Priority each cycle, highest first:
  - `clr[i]`: out=0 and the dwell counter is cleared. If out was 1, out_chg pulses. Any edges in the same cycle are discarded silently (no `dropped`).
  - Dwell active (counter≠0): any `se`/`re` is discarded and `dropped` pulses.
  - `se` and `re` together: apply SIMUL_POLICY.
    - Under policy 0, state is kept and `dropped` pulses.
    - Under policies 1/2, the winning edge is applied as below and the loser is discarded without a `dropped` strobe.
  - `se` only: if out=0, out becomes 1. If out is already 1, there is no change and no strobe (repeats ignored).
  - `re` only: if out=1, out becomes 0. If out is already 0, there is no change and no strobe.
- On every out change not caused by `clr`:
  - The dwell counter loads HOLD_CYCLES.
  - busy=1 while the counter is ≠0.
  - The counter decrements once per cycle and saturates at 0.
- Channels are fully independent. There is no cross-channel interaction.

## Timing
- Latency: for a rising edge first captured at clk edge k, `out` updates at edge k+SYNC_STAGES. `out_chg` is high during the following cycle.
- Minimum input pulse: high and low each ≥ 1 clk period plus setup margin. Narrower pulses may be lost, and this is not flagged.
- Dwell: after a change at edge n, edges whose detection cycle falls before edge n+HOLD_CYCLES are dropped. busy is high for exactly HOLD_CYCLES cycles.
- `clr` acts at the next clk edge, with latency 1.
- Reset mid-dwell or mid-synchronisation: all state returns to the reset values immediately. In-flight edges are lost.

## Structure
- Package `switch_latch_pkg`:
  - policy constants POL_KEEP=0, POL_SET=1, POL_RST=2
  - a function for the dwell counter width, clog2(HOLD_CYCLES+1), minimum 1
- Sub-module `sync_edge_det`:
  - a SYNC_STAGES flip-flop chain plus a history flop
  - outputs a one-cycle rising-edge pulse
  - instantiated 2×NUM_CH times
- The top level generates per-channel latch and dwell logic. The arming counter is shared across channels.

## Test plan
- Reset release with s_in[0] held high: after 10 cycles, out=0 and no out_chg or dropped pulse.
- HOLD_CYCLES=0, SYNC_STAGES=2: s_in[1] pulse captured at edge k.
  - out[1]=1 at edge k+2 and out_chg[1] pulses once.
  - A second s_in[1] pulse leaves out unchanged, with no strobe.
  - An r_in[1] pulse returns out[1] to 0.
- HOLD_CYCLES=5:
  - Set, then r_in 3 cycles after the change: dropped pulses and out stays 1.
  - r_in 6 cycles after the change: out goes to 0.
  - busy is high for exactly 5 cycles.
- Simultaneous s_in/r_in rising on channel 2, with out=0:
  - Policy 0 keeps out=0 and pulses dropped.
  - Policy 1 gives out=1.
  - Policy 2 keeps out=0 with no strobe.
- clr[3] while out[3]=1 and busy=1: out=0 and out_chg pulses at the next edge, busy=0, and an s_in edge in the same cycle is ignored.
- reset asserted mid-dwell on all channels: all outputs are 0 at once, and normal set behaviour resumes after the arming window.
